// File: rtl/mips_pkg.sv
// Shared MIPS load/store definitions: access-size encodings, opcodes and
// the memory access unit state type.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        DONE
    } mau_state_t;

    localparam logic [1:0] SIZE_WORD = 2'b11;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_NONE = 2'b00;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // An invalid size is never aligned, so it is reported as a fault too.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_WORD: return (off == 2'b00);
            SIZE_HALF: return !off[0];
            SIZE_BYTE: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: load lane extraction with sign/zero extension,
// and sub-word merge of store data into a previously read word.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  data_size,
    input  logic        data_sign,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rd_word,
    input  logic [31:0] merge_word,
    input  logic [15:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] merged
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = rd_word[{byte_off, 3'b000} +: 8];
        ld_half = rd_word[{byte_off[1], 4'b0000} +: 16];
        ld_data = rd_word;
        case (data_size)
            SIZE_BYTE: ld_data = {{24{data_sign & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = {{16{data_sign & ld_half[15]}}, ld_half};
            default:   ld_data = rd_word;
        endcase
    end

    always_comb begin
        merged = merge_word;
        case (data_size)
            SIZE_BYTE: merged[{byte_off, 3'b000} +: 8]     = st_data[7:0];
            SIZE_HALF: merged[{byte_off[1], 4'b0000} +: 16] = st_data;
            default:   merged = merge_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: alignment check, single-beat loads and word stores,
// read-modify-write for byte/half stores.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        data_size,
    input  logic              data_sign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    mau_state_t  state, state_nxt;
    logic [31:0] merge_q;
    logic [31:0] ld_data;
    logic [31:0] merged;
    logic        req;
    logic        aligned;

    assign req      = mem_read | mem_write;
    assign aligned  = is_aligned(data_size, addr[1:0]);
    assign mem_addr = addr[ADDR_W-1:2];

    mem_lane_align u_lane (
        .data_size  (data_size),
        .data_sign  (data_sign),
        .byte_off   (addr[1:0]),
        .rd_word    (mem_rdata),
        .merge_word (merge_q),
        .st_data    (wdata[15:0]),
        .ld_data    (ld_data),
        .merged     (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rdata      <= '0;
            merge_q    <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nxt;
            misaligned <= (state == IDLE) && req && !aligned;
            if (state == RD && mem_ready)
                rdata <= ld_data;
            if (state == RMW_RD && mem_ready)
                merge_q <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                // A write wins over a simultaneous read.
                if (req && aligned) begin
                    stall = 1'b1;
                    if (mem_write)
                        state_nxt = (data_size == SIZE_WORD) ? WR : RMW_RD;
                    else
                        state_nxt = RD;
                end
            end
            RD: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) state_nxt = DONE;
            end
            WR: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = wdata;
                if (mem_ready) state_nxt = DONE;
            end
            RMW_RD: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) state_nxt = RMW_WR;
            end
            RMW_WR: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = merged;
                if (mem_ready) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Reset suppresses the bus immediately so an in-flight write never lands.
        if (!rst_n) begin
            state_nxt = IDLE;
            stall     = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [1:0]  data_size;
    logic        data_sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall, misaligned;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned rd_beats = 0;
    int unsigned wr_beats = 0;
    int unsigned we_cycles = 0;
    int unsigned rd0, wr0, we0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .data_size  (data_size),
        .data_sign  (data_sign),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_req && mem_ready) begin
            if (mem_we) wr_beats++;
            else        rd_beats++;
        end
        if (mem_we) we_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                           input logic [31:0] mrd);
        addr = a; data_size = sz; data_sign = sg; mem_rdata = mrd;
        mem_ready = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        step;
        step;
        idle_inputs;
        step;
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; data_size = 2'b00;
        data_sign = 1'b0; addr = '0; wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        step;
        step;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        step;

        // LB 0x1003, sign-extended
        addr = 32'h1003; data_size = 2'b01; data_sign = 1'b1;
        mem_rdata = 32'h80FF_1234; mem_ready = 1'b1; mem_read = 1'b1;
        #1;
        check("lb_idle_stall", 32'(stall), 32'd1);
        check("lb_idle_req", 32'(mem_req), 32'd0);
        step;
        check("lb_rd_req", 32'(mem_req), 32'd1);
        check("lb_rd_we", 32'(mem_we), 32'd0);
        check("lb_rd_addr", 32'(mem_addr), 32'h400);
        check("lb_rd_stall", 32'(stall), 32'd1);
        step;
        check("lb_done_stall", 32'(stall), 32'd0);
        check("lb_done_req", 32'(mem_req), 32'd0);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        idle_inputs;
        step;
        check("lb_rdata_held", rdata, 32'hFFFF_FF80);

        do_load(32'h2002, 2'b10, 1'b0, 32'h9ABC_0001);
        check("lhu_rdata", rdata, 32'h0000_9ABC);
        do_load(32'h2002, 2'b10, 1'b1, 32'h9ABC_0001);
        check("lh_rdata", rdata, 32'hFFFF_9ABC);
        do_load(32'h1002, 2'b01, 1'b0, 32'h80FF_1234);
        check("lbu_rdata", rdata, 32'h0000_00FF);
        do_load(32'h1000, 2'b10, 1'b1, 32'h80FF_1234);
        check("lh_low_pos", rdata, 32'h0000_1234);
        do_load(32'h1004, 2'b11, 1'b1, 32'h80FF_1234);
        check("lw_rdata", rdata, 32'h80FF_1234);

        // SB 0x11 into 0x11223344
        rd0 = rd_beats; wr0 = wr_beats;
        addr = 32'h11; data_size = 2'b01; data_sign = 1'b0; wdata = 32'h0000_00AA;
        mem_rdata = 32'h1122_3344; mem_ready = 1'b1; mem_write = 1'b1;
        #1;
        check("sb_idle_stall", 32'(stall), 32'd1);
        step;
        check("sb_rmwrd_req", 32'(mem_req), 32'd1);
        check("sb_rmwrd_we", 32'(mem_we), 32'd0);
        check("sb_rmwrd_addr", 32'(mem_addr), 32'h4);
        step;
        check("sb_rmwwr_we", 32'(mem_we), 32'd1);
        check("sb_rmwwr_wdata", mem_wdata, 32'h1122_AA44);
        step;
        check("sb_done_req", 32'(mem_req), 32'd0);
        check("sb_done_stall", 32'(stall), 32'd0);
        idle_inputs;
        step;
        check("sb_read_beats", rd_beats - rd0, 32'd1);
        check("sb_write_beats", wr_beats - wr0, 32'd1);

        // SH 0x12 replaces the upper half
        addr = 32'h12; data_size = 2'b10; wdata = 32'h5566_BEEF;
        mem_rdata = 32'h1122_3344; mem_ready = 1'b1; mem_write = 1'b1;
        step;
        step;
        check("sh_rmwwr_wdata", mem_wdata, 32'hBEEF_3344);
        step;
        idle_inputs;
        step;

        // SW with read+write both asserted, memory slow to respond
        addr = 32'h20; data_size = 2'b11; wdata = 32'hDEAD_BEEF;
        mem_ready = 1'b0; mem_read = 1'b1; mem_write = 1'b1;
        #1;
        check("sw_idle_stall", 32'(stall), 32'd1);
        step;
        check("sw_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_wr_addr", 32'(mem_addr), 32'h8);
        for (int i = 0; i < 5; i++) begin
            check("sw_wait_req", 32'(mem_req), 32'd1);
            check("sw_wait_stall", 32'(stall), 32'd1);
            check("sw_wait_we", 32'(mem_we), 32'd1);
            if (i == 4) mem_ready = 1'b1;
            step;
        end
        check("sw_done_req", 32'(mem_req), 32'd0);
        check("sw_done_stall", 32'(stall), 32'd0);
        idle_inputs;
        step;

        // Misaligned LW at 0x6
        rd0 = rd_beats; wr0 = wr_beats;
        addr = 32'h6; data_size = 2'b11; mem_read = 1'b1; mem_ready = 1'b1;
        #1;
        check("lw_mis_stall", 32'(stall), 32'd0);
        check("lw_mis_req", 32'(mem_req), 32'd0);
        step;
        idle_inputs;
        #1;
        check("lw_mis_pulse", 32'(misaligned), 32'd1);
        check("lw_mis_req_after", 32'(mem_req), 32'd0);
        step;
        check("lw_mis_end", 32'(misaligned), 32'd0);

        // Invalid size and odd half address
        addr = 32'h0; data_size = 2'b00; mem_read = 1'b1;
        step;
        idle_inputs;
        #1;
        check("size0_mis", 32'(misaligned), 32'd1);
        step;
        addr = 32'h1; data_size = 2'b10; mem_write = 1'b1;
        #1;
        check("sh_odd_stall", 32'(stall), 32'd0);
        step;
        idle_inputs;
        #1;
        check("sh_odd_mis", 32'(misaligned), 32'd1);
        step;
        check("mis_no_beats", (rd_beats - rd0) + (wr_beats - wr0), 32'd0);
        check("mis_rdata_held", rdata, 32'h80FF_1234);

        // Reset while in RMW_RD abandons the store
        addr = 32'h11; data_size = 2'b01; wdata = 32'hAA;
        mem_ready = 1'b0; mem_write = 1'b1;
        step;
        check("rmw_rst_req_before", 32'(mem_req), 32'd1);
        we0 = we_cycles;
        rst_n = 1'b0;
        #1;
        check("rmw_rst_req_low", 32'(mem_req), 32'd0);
        check("rmw_rst_stall_low", 32'(stall), 32'd0);
        step;
        rst_n = 1'b1;
        idle_inputs;
        mem_ready = 1'b1;
        #1;
        check("rmw_rst_idle_req", 32'(mem_req), 32'd0);
        check("rmw_rst_rdata", rdata, 32'h0);
        step;
        step;
        check("rmw_rst_no_write", we_cycles - we0, 32'd0);
        check("rmw_rst_stall", 32'(stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 mem_read  in  1  decoded load; mem_write  in  1  decoded store.
REQ-005 data_size  in  2  11=word, 10=half, 01=byte, 00=invalid; data_sign  in  1  1=sign-extend load.
REQ-006 addr  in  ADDR_W  byte address; wdata  in  32  store data (low bytes used for sub-word).
REQ-007 rdata  out  32  extended load result; stall  out  1  hold pipeline; misaligned  out  1  alignment-fault pulse.
REQ-008 mem_req  out  1; mem_we  out  1; mem_addr  out  ADDR_W-2  word address; mem_wdata  out  32.
REQ-009 mem_rdata  in  32; mem_ready  in  1  completes the current mem_req beat.

Function
REQ-010 SHALL implement states IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
REQ-011 IDLE: aligned load -> RD; aligned word store -> WR; aligned byte/half store -> RMW_RD; no request -> IDLE.
REQ-012 Simultaneous mem_read and mem_write SHALL be treated as a store.
REQ-013 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or data_size=00; SHALL pulse misaligned 1 cycle in IDLE, issue no mem_req, keep stall low, stay in IDLE.
REQ-014 stall SHALL be combinationally high in IDLE when an aligned request is present, and in RD, WR, RMW_RD, RMW_WR; low in DONE and otherwise.
REQ-015 In RD/WR/RMW_RD/RMW_WR, mem_req SHALL be high, mem_addr = addr[ADDR_W-1:2]; mem_we high only in WR and RMW_WR.
REQ-016 Each memory state SHALL hold until the mem_ready cycle; RD -> DONE, WR -> DONE, RMW_RD -> RMW_WR, RMW_WR -> DONE.
REQ-017 RMW_RD SHALL capture mem_rdata into a merge register; RMW_WR mem_wdata = merge register with lane addr[1:0] (byte) or addr[1] (half) replaced by wdata[7:0]/wdata[15:0].
REQ-018 WR mem_wdata = wdata.
REQ-019 Lanes little-endian: byte k = bits [8k+7:8k]; half h = bits [16h+15:16h].
REQ-020 RD SHALL register rdata on mem_ready: selected lane, sign- or zero-extended per data_sign; word unchanged.
REQ-021 DONE SHALL last exactly one cycle, then -> IDLE; rdata held until next load completes.
REQ-022 Inputs SHALL be sampled live; upstream holds them stable while stall is high.
REQ-023 Minimum latency: load or word store 3 cycles IDLE->DONE with mem_ready immediate; sub-word store 4 cycles.
REQ-024 mem_ready outside memory states SHALL be ignored.

Reset
REQ-025 rst_n low at a clk edge SHALL force IDLE, rdata=0, merge register=0, misaligned=0, regardless of state; outputs mem_req=0, mem_we=0, stall=0 during reset.
REQ-026 Reset mid-transaction SHALL abandon it; no completing write is issued.

Structure
REQ-027 State encoding and data_size encodings (SIZE_WORD/HALF/BYTE) SHALL live in shared package mips_pkg alongside opcode constants.
REQ-028 Lane extraction/extension and lane merge SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-029 LB addr=0x1003, mem_rdata=0x80FF_1234, sign=1 -> rdata=0xFFFF_FF80, mem_addr=0x400, stall high 2 cycles.
REQ-030 LHU addr=0x2002, mem_rdata=0x9ABC_0001 -> rdata=0x0000_9ABC; LH same -> 0xFFFF_9ABC.
REQ-031 SB addr=0x11, wdata=0xAA, memory 0x1122_3344 -> one read, one write mem_wdata=0x1122_AA44, mem_we only in RMW_WR.
REQ-032 LW addr=0x6 -> misaligned 1 cycle, mem_req never high, stall low.
REQ-033 SW with mem_ready held low 5 cycles -> mem_req and stall stay high 5 cycles, DONE on 6th.
REQ-034 rst_n low during RMW_RD -> next cycle IDLE, mem_req=0, no write ever issued.
